// File: rtl/bp_fe_pkg.sv
// Front-end shared types: processor config selector, fetch fault codes and the
// fetch-buffer entry layout macro used by the fetch buffer and its consumers.

`define DECLARE_BP_PROC_PARAMS(bp_params_mp) \
    localparam int vaddr_width_p = bp_fe_pkg::bp_vaddr_width(bp_params_mp)

`define DECLARE_BP_FE_FETCH_ENTRY_S(vaddr_width_mp, fetch_width_mp) \
    typedef struct packed { \
        logic [(vaddr_width_mp)-1:0]     pc; \
        logic [32*(fetch_width_mp)-1:0]  instr; \
        bp_fe_pkg::bp_fe_fetch_fault_e   fault; \
    } bp_fe_fetch_entry_s

package bp_fe_pkg;

    typedef enum logic [1:0] {
        e_bp_inv_cfg     = 2'd0,
        e_bp_default_cfg = 2'd1,
        e_bp_sv48_cfg    = 2'd2
    } bp_params_e;

    typedef enum logic [1:0] {
        e_fetch_none         = 2'd0,
        e_fetch_itlb_miss    = 2'd1,
        e_fetch_icache_miss  = 2'd2,
        e_fetch_access_fault = 2'd3
    } bp_fe_fetch_fault_e;

    // Sv39 unless the config explicitly asks for a wider virtual address space.
    function automatic int bp_vaddr_width(bp_params_e cfg);
        case (cfg)
            e_bp_sv48_cfg: return 48;
            default:       return 39;
        endcase
    endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// Simple-dual-port register file: synchronous write, asynchronous read.

module bsg_mem_1r1w
    #(parameter int width_p = 32
      , parameter int els_p = 4
      , localparam int addr_width_lp = $clog2(els_p)
      )
    (input  logic                     w_clk_i
     , input  logic                     w_v_i
     , input  logic [addr_width_lp-1:0] w_addr_i
     , input  logic [width_p-1:0]       w_data_i
     , input  logic [addr_width_lp-1:0] r_addr_i
     , output logic [width_p-1:0]       r_data_o
     );

    logic [width_p-1:0] mem_r [els_p];

    always_ff @(posedge w_clk_i) begin
        if (w_v_i) begin
            mem_r[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_fe_fetch_buffer.sv
// In-order fetch buffer: slots are reserved at issue, filled by icache responses
// in issue order, and drained at the head; a redirect squashes everything in flight.

module bp_fe_fetch_buffer
    import bp_fe_pkg::*;
    #(parameter bp_params_e bp_params_p = e_bp_inv_cfg
      , `DECLARE_BP_PROC_PARAMS(bp_params_p)
      , parameter int els_p = 4
      , parameter int fetch_width_p = 1
      , localparam int ptr_width_lp = $clog2(els_p)
      , localparam int cnt_width_lp = $clog2(els_p+1)
      )
    (input  logic                          clk_i
     , input  logic                          reset_i

     , input  logic                          issue_v_i
     , input  logic [vaddr_width_p-1:0]      issue_vaddr_i
     , output logic                          issue_ready_o

     , input  logic                          resp_v_i
     , input  logic [32*fetch_width_p-1:0]   resp_data_i
     , input  logic [1:0]                    resp_fault_i

     , input  logic                          flush_i

     , output logic                          deq_v_o
     , output logic [vaddr_width_p-1:0]      deq_pc_o
     , output logic [32*fetch_width_p-1:0]   deq_instr_o
     , output logic [1:0]                    deq_fault_o
     , input  logic                          deq_yumi_i

     , output logic [cnt_width_lp-1:0]       count_o
     );

    localparam int instr_width_lp = 32*fetch_width_p;
    localparam logic [cnt_width_lp+1:0] els_lp = (cnt_width_lp+2)'(els_p);

    if (els_p < 2 || (els_p & (els_p-1)) != 0) begin : g_bad_els
        $error("bp_fe_fetch_buffer: els_p must be a power of two, at least 2");
    end
    if (fetch_width_p != 1 && fetch_width_p != 2) begin : g_bad_fetch_width
        $error("bp_fe_fetch_buffer: fetch_width_p must be 1 or 2");
    end

    `DECLARE_BP_FE_FETCH_ENTRY_S(vaddr_width_p, fetch_width_p);

    logic [ptr_width_lp-1:0] alloc_ptr_r, alloc_ptr_n;
    logic [ptr_width_lp-1:0] fill_ptr_r, fill_ptr_n;
    logic [ptr_width_lp-1:0] read_ptr_r, read_ptr_n;
    logic [cnt_width_lp-1:0] filled_cnt_r, filled_cnt_n;
    logic [cnt_width_lp-1:0] pending_cnt_r, pending_cnt_n;
    logic [cnt_width_lp-1:0] squash_cnt_r, squash_cnt_n;

    logic [cnt_width_lp+1:0] occupancy;
    logic [cnt_width_lp:0]   squash_total;
    logic issue_fire, resp_fill, resp_drop, deq_fire;

    // Squashed fetches still hold a slot until their response drains, so they count as occupied.
    assign occupancy     = {2'b0, filled_cnt_r} + {2'b0, pending_cnt_r} + {2'b0, squash_cnt_r};
    assign issue_ready_o = (occupancy < els_lp);

    assign issue_fire = issue_v_i & issue_ready_o;
    assign resp_fill  = resp_v_i & (squash_cnt_r == '0) & ~flush_i;
    assign resp_drop  = resp_v_i & (squash_cnt_r != '0) & ~flush_i;
    assign deq_fire   = deq_yumi_i & ~flush_i;

    // A response coinciding with the flush is the oldest in-flight fetch, already retired here.
    assign squash_total = {1'b0, squash_cnt_r} + {1'b0, pending_cnt_r};

    always_comb begin
        alloc_ptr_n   = alloc_ptr_r;
        fill_ptr_n    = fill_ptr_r;
        read_ptr_n    = read_ptr_r;
        filled_cnt_n  = filled_cnt_r;
        pending_cnt_n = pending_cnt_r;
        squash_cnt_n  = squash_cnt_r;

        if (flush_i) begin
            squash_cnt_n  = cnt_width_lp'(squash_total
                            - (cnt_width_lp+1)'(resp_v_i && (squash_total != '0)));
            filled_cnt_n  = '0;
            pending_cnt_n = cnt_width_lp'(issue_fire);
            read_ptr_n    = alloc_ptr_r;
            fill_ptr_n    = alloc_ptr_r;
            alloc_ptr_n   = alloc_ptr_r + ptr_width_lp'(issue_fire);
        end else begin
            alloc_ptr_n   = alloc_ptr_r + ptr_width_lp'(issue_fire);
            fill_ptr_n    = fill_ptr_r + ptr_width_lp'(resp_fill);
            read_ptr_n    = read_ptr_r + ptr_width_lp'(deq_fire);
            pending_cnt_n = pending_cnt_r + cnt_width_lp'(issue_fire) - cnt_width_lp'(resp_fill);
            filled_cnt_n  = filled_cnt_r + cnt_width_lp'(resp_fill) - cnt_width_lp'(deq_fire);
            squash_cnt_n  = squash_cnt_r - cnt_width_lp'(resp_drop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            alloc_ptr_r   <= '0;
            fill_ptr_r    <= '0;
            read_ptr_r    <= '0;
            filled_cnt_r  <= '0;
            pending_cnt_r <= '0;
            squash_cnt_r  <= '0;
        end else begin
            alloc_ptr_r   <= alloc_ptr_n;
            fill_ptr_r    <= fill_ptr_n;
            read_ptr_r    <= read_ptr_n;
            filled_cnt_r  <= filled_cnt_n;
            pending_cnt_r <= pending_cnt_n;
            squash_cnt_r  <= squash_cnt_n;
        end
    end

    logic [vaddr_width_p-1:0]    head_pc;
    logic [instr_width_lp+1:0]   head_data;
    bp_fe_fetch_entry_s          head_entry;

    bsg_mem_1r1w #(.width_p(vaddr_width_p), .els_p(els_p)) pc_mem
        (.w_clk_i(clk_i)
         , .w_v_i(issue_fire)
         , .w_addr_i(alloc_ptr_r)
         , .w_data_i(issue_vaddr_i)
         , .r_addr_i(read_ptr_r)
         , .r_data_o(head_pc)
         );

    bsg_mem_1r1w #(.width_p(instr_width_lp+2), .els_p(els_p)) data_mem
        (.w_clk_i(clk_i)
         , .w_v_i(resp_fill)
         , .w_addr_i(fill_ptr_r)
         , .w_data_i({resp_data_i, resp_fault_i})
         , .r_addr_i(read_ptr_r)
         , .r_data_o(head_data)
         );

    assign head_entry.pc    = head_pc;
    assign head_entry.instr = head_data[instr_width_lp+1:2];
    assign head_entry.fault = bp_fe_fetch_fault_e'(head_data[1:0]);

    assign deq_v_o     = (filled_cnt_r != '0);
    assign deq_pc_o    = head_entry.pc;
    assign deq_instr_o = head_entry.instr;
    assign deq_fault_o = head_entry.fault;
    assign count_o     = filled_cnt_r;

    // Protocol checks on the producer/consumer handshakes.
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(resp_v_i && pending_cnt_r == '0 && squash_cnt_r == '0))
                else $error("bp_fe_fetch_buffer: response with no outstanding fetch");
            assert (!(issue_v_i && !issue_ready_o))
                else $error("bp_fe_fetch_buffer: issue while not ready");
            assert (!(deq_yumi_i && !deq_v_o))
                else $error("bp_fe_fetch_buffer: yumi while head is empty");
        end
    end

endmodule

// File: tb/tb_bp_fe_fetch_buffer.sv
// Directed bench for the fetch buffer: a reference queue model tracks issued pcs,
// squashed responses and filled entries, and every dequeue is checked against it.

module tb_bp_fe_fetch_buffer;
    import bp_fe_pkg::*;

    localparam int els_lp     = 4;
    localparam int vaddr_w_lp = bp_vaddr_width(e_bp_inv_cfg);

    logic                  clk_i = 1'b0;
    logic                  reset_i = 1'b1;
    logic                  issue_v_i = 1'b0;
    logic [vaddr_w_lp-1:0] issue_vaddr_i = '0;
    logic                  issue_ready_o;
    logic                  resp_v_i = 1'b0;
    logic [31:0]           resp_data_i = '0;
    logic [1:0]            resp_fault_i = '0;
    logic                  flush_i = 1'b0;
    logic                  deq_v_o;
    logic [vaddr_w_lp-1:0] deq_pc_o;
    logic [31:0]           deq_instr_o;
    logic [1:0]            deq_fault_o;
    logic                  deq_yumi_i = 1'b0;
    logic [2:0]            count_o;

    bp_fe_fetch_buffer #(.bp_params_p(e_bp_inv_cfg), .els_p(els_lp), .fetch_width_p(1)) dut
        (.clk_i(clk_i)
         , .reset_i(reset_i)
         , .issue_v_i(issue_v_i)
         , .issue_vaddr_i(issue_vaddr_i)
         , .issue_ready_o(issue_ready_o)
         , .resp_v_i(resp_v_i)
         , .resp_data_i(resp_data_i)
         , .resp_fault_i(resp_fault_i)
         , .flush_i(flush_i)
         , .deq_v_o(deq_v_o)
         , .deq_pc_o(deq_pc_o)
         , .deq_instr_o(deq_instr_o)
         , .deq_fault_o(deq_fault_o)
         , .deq_yumi_i(deq_yumi_i)
         , .count_o(count_o)
         );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [vaddr_w_lp-1:0] pc;
        logic [31:0]           instr;
        logic [1:0]            fault;
    } exp_entry_t;

    exp_entry_t            exp_q[$];
    logic [vaddr_w_lp-1:0] pc_q[$];
    int                    m_squash;
    int                    tests_run;
    int                    tests_failed;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock of stimulus: check the registered outputs, drive, clock, then advance the model.
    task automatic applyStimulus(input logic issue, input logic [vaddr_w_lp-1:0] vaddr,
                                 input logic resp, input logic [31:0] data, input logic [1:0] fault,
                                 input logic flush, input logic yumi);
        exp_entry_t e;
        int occupancy;
        logic ready;
        occupancy = exp_q.size() + pc_q.size() + m_squash;
        ready = (occupancy < els_lp);
        checkOutput("issue_ready", 64'(issue_ready_o), 64'(ready));
        checkOutput("deq_v", 64'(deq_v_o), 64'(exp_q.size() != 0));
        checkOutput("count", 64'(count_o), 64'(exp_q.size()));
        if (yumi && exp_q.size() != 0) begin
            e = exp_q[0];
            checkOutput("deq_pc", 64'(deq_pc_o), 64'(e.pc));
            checkOutput("deq_instr", 64'(deq_instr_o), 64'(e.instr));
            checkOutput("deq_fault", 64'(deq_fault_o), 64'(e.fault));
        end

        issue_v_i     = issue;
        issue_vaddr_i = vaddr;
        resp_v_i      = resp;
        resp_data_i   = data;
        resp_fault_i  = fault;
        flush_i       = flush;
        deq_yumi_i    = yumi;
        @(posedge clk_i);
        #1;

        if (flush) begin
            if (resp) begin
                if (m_squash > 0) m_squash--;
                else if (pc_q.size() != 0) void'(pc_q.pop_front());
            end
            m_squash += pc_q.size();
            pc_q.delete();
            exp_q.delete();
        end else begin
            if (yumi && exp_q.size() != 0) void'(exp_q.pop_front());
            if (resp) begin
                if (m_squash > 0) m_squash--;
                else if (pc_q.size() != 0) begin
                    e.pc    = pc_q.pop_front();
                    e.instr = data;
                    e.fault = fault;
                    exp_q.push_back(e);
                end
            end
        end
        if (issue && ready) pc_q.push_back(vaddr);

        issue_v_i  = 1'b0;
        resp_v_i   = 1'b0;
        flush_i    = 1'b0;
        deq_yumi_i = 1'b0;
    endtask

    task automatic resetDut();
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("reset_deq_v", 64'(deq_v_o), 64'(0));
        checkOutput("reset_count", 64'(count_o), 64'(0));
        checkOutput("reset_issue_ready", 64'(issue_ready_o), 64'(1));
        exp_q.delete();
        pc_q.delete();
        m_squash = 0;
        reset_i = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_squash     = 0;
        resetDut();

        // Fill all four slots, then respond and drain in order.
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 39'h100 + 39'(4*i), 0, '0, 2'd0, 0, 0);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, '0, 1, 32'hA000_0000 + 32'(i), 2'd0, 0, 0);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, '0, 0, '0, 2'd0, 0, 1);

        // Two stale fetches squashed by a redirect; the post-flush ones must come through.
        applyStimulus(1, 39'h180, 0, '0, 2'd0, 0, 0);
        applyStimulus(1, 39'h184, 0, '0, 2'd0, 0, 0);
        applyStimulus(0, '0, 0, '0, 2'd0, 1, 0);
        applyStimulus(1, 39'h200, 0, '0, 2'd0, 0, 0);
        applyStimulus(1, 39'h204, 0, '0, 2'd0, 0, 0);
        applyStimulus(0, '0, 1, 32'hDEAD_0001, 2'd0, 0, 0);
        applyStimulus(0, '0, 1, 32'hDEAD_0002, 2'd0, 0, 0);
        applyStimulus(0, '0, 1, 32'h0000_0200, 2'd0, 0, 0);
        applyStimulus(0, '0, 1, 32'h0000_0204, 2'd1, 0, 0);
        applyStimulus(0, '0, 0, '0, 2'd0, 0, 1);
        applyStimulus(0, '0, 0, '0, 2'd0, 0, 1);

        // Steady state: issue, respond and dequeue every cycle with one entry resident.
        applyStimulus(1, 39'h300, 0, '0, 2'd0, 0, 0);
        applyStimulus(1, 39'h304, 1, 32'hC000_1000, 2'd0, 0, 0);
        for (int i = 0; i < 20; i++)
            applyStimulus(1, 39'h308 + 39'(4*i), 1, 32'hC000_0000 + 32'(i), 2'(i % 4), 0, 1);
        applyStimulus(0, '0, 1, 32'hC000_2000, 2'd0, 0, 1);
        applyStimulus(0, '0, 0, '0, 2'd0, 0, 1);

        // Faulting fetch, then a flush that collides with a response, a yumi and a new issue.
        applyStimulus(1, 39'h400, 0, '0, 2'd0, 0, 0);
        applyStimulus(0, '0, 1, 32'h0000_0BAD, 2'd2, 0, 0);
        applyStimulus(0, '0, 0, '0, 2'd0, 0, 1);
        applyStimulus(1, 39'h500, 0, '0, 2'd0, 0, 0);
        applyStimulus(1, 39'h504, 1, 32'h5555_0500, 2'd0, 0, 0);
        applyStimulus(1, 39'h600, 1, 32'h5555_0504, 2'd0, 1, 1);
        applyStimulus(0, '0, 1, 32'h6666_0600, 2'd3, 0, 0);
        applyStimulus(0, '0, 0, '0, 2'd0, 0, 1);

        // Reset with three pending and one filled entry drops everything.
        applyStimulus(1, 39'h700, 0, '0, 2'd0, 0, 0);
        applyStimulus(1, 39'h704, 1, 32'h7777_0700, 2'd0, 0, 0);
        applyStimulus(1, 39'h708, 0, '0, 2'd0, 0, 0);
        applyStimulus(1, 39'h70C, 0, '0, 2'd0, 0, 0);
        resetDut();
        applyStimulus(1, 39'h800, 0, '0, 2'd0, 0, 0);
        applyStimulus(0, '0, 1, 32'h8888_0800, 2'd1, 0, 0);
        applyStimulus(0, '0, 0, '0, 2'd0, 0, 1);
        applyStimulus(0, '0, 0, '0, 2'd0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
